// File: rtl/h14_pkg.sv
// Shared constants and the BCH(64,56)/(32,24) ECC step used by both the
// data-island transmitter and receiver.
package h14_pkg;

  localparam int PKT_CYCLES    = 32;
  localparam int HDR_DATA_BITS = 24;
  localparam int SUB_DATA_BITS = 56;
  localparam int SUB_LANES     = 4;

  localparam logic [7:0] BCH_POLY = 8'h83;

  localparam int CHUNK_HDR_BIT = 0;
  localparam int CHUNK_CH1_LSB = 1;
  localparam int CHUNK_CH2_LSB = 5;

  // First cycle of each packet that carries ECC bits instead of data
  localparam int HDR_ECC_CYCLE = HDR_DATA_BITS;
  localparam int SUB_ECC_CYCLE = SUB_DATA_BITS / 2;

  typedef enum logic {
    ST_IDLE,
    ST_COLLECT
  } rx_state_t;

  function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic data_bit);
    return {1'b0, ecc[7:1]} ^ ({8{ecc[0] ^ data_bit}} & BCH_POLY);
  endfunction

endpackage

// File: rtl/h14rx_bch_checker.sv
// One ECC lane: runs the BCH LFSR over data bits, then compares the received
// ECC bits against it, raising a sticky error for the current packet.
module h14rx_bch_checker
  import h14_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      shift,
  input  logic [BITS_PER_CYCLE-1:0] data,
  input  logic                      ecc_phase,
  output logic                      err
);

  logic [7:0] ecc_q;
  logic [7:0] ecc_d;
  logic       err_q;
  logic       mismatch;

  // In the ECC phase the register shifts right so its low bits always line up
  // with the ECC bits arriving on this cycle.
  always_comb begin
    ecc_d    = ecc_q;
    mismatch = 1'b0;
    if (start) begin
      ecc_d = 8'h00;
      for (int i = 0; i < BITS_PER_CYCLE; i++) ecc_d = bch_step(ecc_d, data[i]);
    end else if (shift) begin
      if (ecc_phase) begin
        mismatch = (data != ecc_q[BITS_PER_CYCLE-1:0]);
        ecc_d    = ecc_q >> BITS_PER_CYCLE;
      end else begin
        for (int i = 0; i < BITS_PER_CYCLE; i++) ecc_d = bch_step(ecc_d, data[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ecc_q <= 8'h00;
      err_q <= 1'b0;
    end else begin
      ecc_q <= ecc_d;
      if (start) err_q <= 1'b0;
      else if (mismatch) err_q <= 1'b1;
    end
  end

  // Includes the current cycle so the last ECC bit is seen on the final chunk
  assign err = err_q | mismatch;

endmodule

// File: rtl/h14rx_packet_disassembler.sv
// Rebuilds header and subpackets of each 32-cycle data-island packet from the
// 9-bit chunk stream, checks all five ECC bytes and flags aborted packets.
module h14rx_packet_disassembler
  import h14_pkg::*;
#(
  parameter bit CHECK_ECC = 1'b1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  input  logic                                     in_sof,
  input  logic [8:0]                               chunk,
  output logic [HDR_DATA_BITS-1:0]                 header,
  output logic [SUB_LANES-1:0][SUB_DATA_BITS-1:0]  sub,
  output logic                                     pkt_valid,
  output logic                                     hdr_ecc_err,
  output logic [SUB_LANES-1:0]                     sub_ecc_err,
  output logic                                     pkt_abort
);

  rx_state_t state, state_next;
  logic [4:0] counter;
  logic       start, accept, done, abort_now;
  logic [4:0] cyc_idx;
  logic [HDR_DATA_BITS-1:0]                hdr_buf;
  logic [SUB_LANES-1:0][SUB_DATA_BITS-1:0] sub_buf;
  logic                 hdr_err_now;
  logic [SUB_LANES-1:0] sub_err_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      counter <= 5'd0;
    end else begin
      state <= state_next;
      if (start) counter <= 5'd1;
      else if (accept) counter <= counter + 5'd1;
      else if (abort_now) counter <= 5'd0;
    end
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    accept     = 1'b0;
    done       = 1'b0;
    abort_now  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid && in_sof) begin
          start      = 1'b1;
          state_next = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (!in_valid) begin
          abort_now  = 1'b1;
          state_next = ST_IDLE;
        end else if (in_sof) begin
          // Restart: the new sof chunk becomes chunk 0 of a fresh packet
          abort_now = 1'b1;
          start     = 1'b1;
        end else begin
          accept = 1'b1;
          if (counter == 5'd31) begin
            done       = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
    endcase
  end

  assign cyc_idx = start ? 5'd0 : counter;

  // Every data bit position is rewritten each packet, so no clear is needed
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_buf <= '0;
      sub_buf <= '0;
    end else if (start || accept) begin
      if (cyc_idx < 5'(HDR_ECC_CYCLE)) hdr_buf[cyc_idx] <= chunk[CHUNK_HDR_BIT];
      if (cyc_idx < 5'(SUB_ECC_CYCLE)) begin
        for (int k = 0; k < SUB_LANES; k++) begin
          sub_buf[k][{cyc_idx, 1'b0}] <= chunk[CHUNK_CH1_LSB+k];
          sub_buf[k][{cyc_idx, 1'b1}] <= chunk[CHUNK_CH2_LSB+k];
        end
      end
    end
  end

  h14rx_bch_checker #(.BITS_PER_CYCLE(1)) u_hdr_bch (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .shift     (accept),
    .data      (chunk[CHUNK_HDR_BIT]),
    .ecc_phase (cyc_idx >= 5'(HDR_ECC_CYCLE)),
    .err       (hdr_err_now)
  );

  for (genvar k = 0; k < SUB_LANES; k++) begin : g_sub_bch
    h14rx_bch_checker #(.BITS_PER_CYCLE(2)) u_sub_bch (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .shift     (accept),
      .data      ({chunk[CHUNK_CH2_LSB+k], chunk[CHUNK_CH1_LSB+k]}),
      .ecc_phase (cyc_idx >= 5'(SUB_ECC_CYCLE)),
      .err       (sub_err_now[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      header      <= '0;
      sub         <= '0;
      pkt_valid   <= 1'b0;
      hdr_ecc_err <= 1'b0;
      sub_ecc_err <= '0;
      pkt_abort   <= 1'b0;
    end else begin
      pkt_valid <= done;
      pkt_abort <= abort_now;
      if (done) begin
        header      <= hdr_buf;
        sub         <= sub_buf;
        hdr_ecc_err <= CHECK_ECC & hdr_err_now;
        sub_ecc_err <= CHECK_ECC ? sub_err_now : '0;
      end
    end
  end

endmodule

// File: tb/tb_h14rx_packet_disassembler.sv
// Directed self-checking bench for h14rx_packet_disassembler: builds encoded
// packets locally and checks reconstruction, ECC flags, aborts and reset.
module tb_h14rx_packet_disassembler;

  localparam logic [23:0]        A_HDR = 24'h0D0282;
  localparam logic [3:0][55:0]   A_SUB = {56'hFE_DC_BA_98_76_54_32, 56'h01_23_45_67_89_AB_CD,
                                          56'h00_11_22_33_44_55_66, 56'h00_00_00_28_08_10_4D};
  localparam logic [23:0]        B_HDR = 24'h0A0184;
  localparam logic [3:0][55:0]   B_SUB = {56'h80_00_00_00_00_00_01, 56'h0F_0E_0D_0C_0B_0A_09,
                                          56'h55_AA_55_AA_55_AA_55, 56'h00_00_00_00_00_01_70};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_sof = 1'b0;
  logic [8:0]        chunk = 9'h000;
  logic [23:0]       header;
  logic [3:0][55:0]  sub;
  logic              pkt_valid;
  logic              hdr_ecc_err;
  logic [3:0]        sub_ecc_err;
  logic              pkt_abort;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int abort_cnt = 0;
  int valid_cyc[$];

  logic [31:0][8:0] chunks_a, chunks_b, work;

  h14rx_packet_disassembler dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .chunk       (chunk),
    .header      (header),
    .sub         (sub),
    .pkt_valid   (pkt_valid),
    .hdr_ecc_err (hdr_ecc_err),
    .sub_ecc_err (sub_ecc_err),
    .pkt_abort   (pkt_abort)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (pkt_valid === 1'b1) begin
      valid_cnt++;
      valid_cyc.push_back(cyc);
    end
    if (pkt_abort === 1'b1) abort_cnt++;
  end

  function automatic logic [7:0] tb_bch(input logic [7:0] e, input logic b);
    logic fb;
    fb = e[0] ^ b;
    e  = e >> 1;
    if (fb) e = e ^ 8'h83;
    return e;
  endfunction

  task automatic build_packet(input logic [23:0] h, input logic [3:0][55:0] s,
                              output logic [31:0][8:0] ch);
    logic [7:0]       e;
    logic [31:0]      hf;
    logic [3:0][63:0] sf;
    e = 8'h00;
    for (int i = 0; i < 24; i++) e = tb_bch(e, h[i]);
    hf = {e, h};
    for (int k = 0; k < 4; k++) begin
      e = 8'h00;
      for (int i = 0; i < 56; i++) e = tb_bch(e, s[k][i]);
      sf[k] = {e, s[k]};
    end
    for (int n = 0; n < 32; n++) begin
      ch[n][0] = hf[n];
      for (int k = 0; k < 4; k++) begin
        ch[n][1+k] = sf[k][2*n];
        ch[n][5+k] = sf[k][2*n+1];
      end
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [8:0] c);
    in_valid = v;
    in_sof   = s;
    chunk    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0][8:0] ch, input int first, input int last);
    for (int n = first; n <= last; n++) drive(1'b1, (n == 0), ch[n]);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, 1'b0, 9'h000);
    drive(1'b0, 1'b0, 9'h000);
    rst = 1'b0;
    checks++; if (header !== 24'h0) $display("[TB] FAIL reset header: got %h expected %h", header, 24'h0); else passes++;
    checks++; if (sub !== '0) $display("[TB] FAIL reset sub: got %h expected 0", sub); else passes++;
    checks++; if (pkt_valid !== 1'b0) $display("[TB] FAIL reset pkt_valid: got %b expected 0", pkt_valid); else passes++;
    checks++; if (pkt_abort !== 1'b0) $display("[TB] FAIL reset pkt_abort: got %b expected 0", pkt_abort); else passes++;
    checks++; if ({hdr_ecc_err, sub_ecc_err} !== 5'b0) $display("[TB] FAIL reset ecc_err: got %b expected 00000", {hdr_ecc_err, sub_ecc_err}); else passes++;
  endtask

  task automatic test_null_packet;
    work = '0;
    send(work, 0, 30);
    checks++; if (pkt_valid !== 1'b0) $display("[TB] FAIL null early pkt_valid: got %b expected 0", pkt_valid); else passes++;
    send(work, 31, 31);
    checks++; if (pkt_valid !== 1'b1) $display("[TB] FAIL null pkt_valid: got %b expected 1", pkt_valid); else passes++;
    checks++; if (header !== 24'h0) $display("[TB] FAIL null header: got %h expected 0", header); else passes++;
    checks++; if (sub !== '0) $display("[TB] FAIL null sub: got %h expected 0", sub); else passes++;
    checks++; if ({hdr_ecc_err, sub_ecc_err} !== 5'b0) $display("[TB] FAIL null ecc_err: got %b expected 00000", {hdr_ecc_err, sub_ecc_err}); else passes++;
    drive(1'b0, 1'b0, 9'h000);
    checks++; if (pkt_valid !== 1'b0) $display("[TB] FAIL null pulse width: got %b expected 0", pkt_valid); else passes++;
  endtask

  task automatic test_loopback;
    send(chunks_a, 0, 30);
    checks++; if (pkt_valid !== 1'b0) $display("[TB] FAIL loop early pkt_valid: got %b expected 0", pkt_valid); else passes++;
    send(chunks_a, 31, 31);
    checks++; if (pkt_valid !== 1'b1) $display("[TB] FAIL loop pkt_valid: got %b expected 1", pkt_valid); else passes++;
    checks++; if (header !== A_HDR) $display("[TB] FAIL loop header: got %h expected %h", header, A_HDR); else passes++;
    checks++; if (sub !== A_SUB) $display("[TB] FAIL loop sub: got %h expected %h", sub, A_SUB); else passes++;
    checks++; if (hdr_ecc_err !== 1'b0) $display("[TB] FAIL loop hdr_ecc_err: got %b expected 0", hdr_ecc_err); else passes++;
    checks++; if (sub_ecc_err !== 4'b0) $display("[TB] FAIL loop sub_ecc_err: got %b expected 0000", sub_ecc_err); else passes++;
    drive(1'b0, 1'b0, 9'h000);
  endtask

  task automatic test_ecc_error;
    work = chunks_a;
    work[5][0]  = ~work[5][0];
    work[30][6] = ~work[30][6];
    send(work, 0, 31);
    checks++; if (pkt_valid !== 1'b1) $display("[TB] FAIL err pkt_valid: got %b expected 1", pkt_valid); else passes++;
    checks++; if (header !== (A_HDR ^ 24'h20)) $display("[TB] FAIL err header: got %h expected %h", header, A_HDR ^ 24'h20); else passes++;
    checks++; if (sub !== A_SUB) $display("[TB] FAIL err sub: got %h expected %h", sub, A_SUB); else passes++;
    checks++; if (hdr_ecc_err !== 1'b1) $display("[TB] FAIL err hdr_ecc_err: got %b expected 1", hdr_ecc_err); else passes++;
    checks++; if (sub_ecc_err !== 4'b0010) $display("[TB] FAIL err sub_ecc_err: got %b expected 0010", sub_ecc_err); else passes++;
    drive(1'b0, 1'b0, 9'h000);
  endtask

  task automatic test_abort_invalid;
    int a0, v0;
    a0 = abort_cnt;
    v0 = valid_cnt;
    send(chunks_b, 0, 9);
    drive(1'b0, 1'b0, 9'h000);
    checks++; if (pkt_abort !== 1'b1) $display("[TB] FAIL drop pkt_abort: got %b expected 1", pkt_abort); else passes++;
    checks++; if (pkt_valid !== 1'b0) $display("[TB] FAIL drop pkt_valid: got %b expected 0", pkt_valid); else passes++;
    checks++; if (header !== (A_HDR ^ 24'h20)) $display("[TB] FAIL drop header held: got %h expected %h", header, A_HDR ^ 24'h20); else passes++;
    checks++; if (sub_ecc_err !== 4'b0010) $display("[TB] FAIL drop sub_ecc_err held: got %b expected 0010", sub_ecc_err); else passes++;
    drive(1'b0, 1'b0, 9'h000);
    checks++; if (pkt_abort !== 1'b0) $display("[TB] FAIL drop abort width: got %b expected 0", pkt_abort); else passes++;
    send(chunks_a, 0, 31);
    checks++; if (pkt_valid !== 1'b1) $display("[TB] FAIL drop resume pkt_valid: got %b expected 1", pkt_valid); else passes++;
    checks++; if (header !== A_HDR) $display("[TB] FAIL drop resume header: got %h expected %h", header, A_HDR); else passes++;
    checks++; if ({hdr_ecc_err, sub_ecc_err} !== 5'b0) $display("[TB] FAIL drop resume ecc_err: got %b expected 00000", {hdr_ecc_err, sub_ecc_err}); else passes++;
    drive(1'b0, 1'b0, 9'h000);
    checks++; if (abort_cnt - a0 !== 1) $display("[TB] FAIL drop abort count: got %0d expected 1", abort_cnt - a0); else passes++;
    checks++; if (valid_cnt - v0 !== 1) $display("[TB] FAIL drop valid count: got %0d expected 1", valid_cnt - v0); else passes++;
  endtask

  task automatic test_sof_restart;
    int a0, v0;
    a0 = abort_cnt;
    v0 = valid_cnt;
    send(chunks_a, 0, 16);
    send(chunks_b, 0, 0);
    checks++; if (pkt_abort !== 1'b1) $display("[TB] FAIL restart pkt_abort: got %b expected 1", pkt_abort); else passes++;
    send(chunks_b, 1, 30);
    checks++; if (pkt_valid !== 1'b0) $display("[TB] FAIL restart early pkt_valid: got %b expected 0", pkt_valid); else passes++;
    send(chunks_b, 31, 31);
    checks++; if (pkt_valid !== 1'b1) $display("[TB] FAIL restart pkt_valid: got %b expected 1", pkt_valid); else passes++;
    checks++; if (header !== B_HDR) $display("[TB] FAIL restart header: got %h expected %h", header, B_HDR); else passes++;
    checks++; if (sub !== B_SUB) $display("[TB] FAIL restart sub: got %h expected %h", sub, B_SUB); else passes++;
    checks++; if ({hdr_ecc_err, sub_ecc_err} !== 5'b0) $display("[TB] FAIL restart ecc_err: got %b expected 00000", {hdr_ecc_err, sub_ecc_err}); else passes++;
    drive(1'b0, 1'b0, 9'h000);
    checks++; if (abort_cnt - a0 !== 1) $display("[TB] FAIL restart abort count: got %0d expected 1", abort_cnt - a0); else passes++;
    checks++; if (valid_cnt - v0 !== 1) $display("[TB] FAIL restart valid count: got %0d expected 1", valid_cnt - v0); else passes++;
  endtask

  task automatic test_back_to_back;
    int base, a1, v1, gap;
    base = valid_cyc.size();
    send(chunks_a, 0, 31);
    checks++; if (pkt_valid !== 1'b1) $display("[TB] FAIL b2b first pkt_valid: got %b expected 1", pkt_valid); else passes++;
    checks++; if (header !== A_HDR) $display("[TB] FAIL b2b first header: got %h expected %h", header, A_HDR); else passes++;
    send(chunks_b, 0, 31);
    checks++; if (pkt_valid !== 1'b1) $display("[TB] FAIL b2b second pkt_valid: got %b expected 1", pkt_valid); else passes++;
    checks++; if (header !== B_HDR) $display("[TB] FAIL b2b second header: got %h expected %h", header, B_HDR); else passes++;
    checks++; if (sub !== B_SUB) $display("[TB] FAIL b2b second sub: got %h expected %h", sub, B_SUB); else passes++;
    send(chunks_a, 0, 11);
    a1 = abort_cnt;
    v1 = valid_cnt;
    rst = 1'b1;
    drive(1'b1, 1'b0, chunks_a[12]);
    rst = 1'b0;
    checks++; if (header !== 24'h0) $display("[TB] FAIL rst header: got %h expected 0", header); else passes++;
    checks++; if (sub !== '0) $display("[TB] FAIL rst sub: got %h expected 0", sub); else passes++;
    checks++; if ({pkt_valid, pkt_abort} !== 2'b00) $display("[TB] FAIL rst pulses: got %b expected 00", {pkt_valid, pkt_abort}); else passes++;
    for (int n = 13; n < 21; n++) drive(1'b1, 1'b0, chunks_a[n]);
    drive(1'b0, 1'b0, 9'h000);
    drive(1'b0, 1'b0, 9'h000);
    checks++; if (valid_cnt !== v1) $display("[TB] FAIL rst valid count: got %0d expected %0d", valid_cnt, v1); else passes++;
    checks++; if (abort_cnt !== a1) $display("[TB] FAIL rst abort count: got %0d expected %0d", abort_cnt, a1); else passes++;
    gap = (valid_cyc.size() >= base + 2) ? (valid_cyc[base+1] - valid_cyc[base]) : -1;
    checks++; if (valid_cyc.size() - base !== 2) $display("[TB] FAIL b2b pulse count: got %0d expected 2", valid_cyc.size() - base); else passes++;
    checks++; if (gap !== 32) $display("[TB] FAIL b2b pulse spacing: got %0d expected 32", gap); else passes++;
    send(chunks_a, 0, 31);
    checks++; if (pkt_valid !== 1'b1) $display("[TB] FAIL post-rst pkt_valid: got %b expected 1", pkt_valid); else passes++;
    checks++; if (header !== A_HDR) $display("[TB] FAIL post-rst header: got %h expected %h", header, A_HDR); else passes++;
    drive(1'b0, 1'b0, 9'h000);
  endtask

  initial begin
    build_packet(A_HDR, A_SUB, chunks_a);
    build_packet(B_HDR, B_SUB, chunks_b);
    test_reset;
    test_null_packet;
    test_loopback;
    test_ecc_error;
    test_abort_invalid;
    test_sof_restart;
    test_back_to_back;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
